// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 active-low keypad matrix one row at a time.
// Whole frames are debounced, and press/release events are queued for the game logic.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 512,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic        evt_press,
    output logic [15:0] held,
    output logic        overflow
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_t;

    // Matrix position (row*4+col) to keycode.
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:    key_code = 4'd1;
            4'd1:    key_code = 4'd2;
            4'd2:    key_code = 4'd3;
            4'd3:    key_code = 4'd10;
            4'd4:    key_code = 4'd4;
            4'd5:    key_code = 4'd5;
            4'd6:    key_code = 4'd6;
            4'd7:    key_code = 4'd11;
            4'd8:    key_code = 4'd7;
            4'd9:    key_code = 4'd8;
            4'd10:   key_code = 4'd9;
            4'd11:   key_code = 4'd12;
            4'd12:   key_code = 4'd14;
            4'd13:   key_code = 4'd0;
            4'd14:   key_code = 4'd15;
            4'd15:   key_code = 4'd13;
            default: key_code = 4'd0;
        endcase
    endfunction

    logic [CW-1:0]  slot_cnt_r;
    logic           adv_r;
    logic [1:0]     row_idx_r;
    logic [3:0]     rows_r;
    logic [15:0]    raw_r;
    logic [15:0]    prev_raw_r;
    logic [3:0]     m_r;
    logic [15:0]    held_r;
    logic [15:0]    changed_r;
    emit_state_t    state_r;
    logic [3:0]     idx_r;
    logic [4:0]     mem_r [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic           overflow_r;

    logic           sample_s;
    logic           frame_end_s;
    logic [15:0]    raw_next_s;
    logic [3:0]     m_inc_s;
    logic [3:0]     m_next_s;
    logic           commit_s;
    emit_state_t    state_next_s;
    logic [3:0]     idx_next_s;
    logic           push_s;
    logic [4:0]     push_data_s;
    logic           empty_s;
    logic           full_s;
    logic           pop_s;
    logic           wr_en_s;
    logic           drop_s;
    logic [4:0]     head_s;

    // Sample point, frame assembly and debounce decision for this cycle.
    always_comb begin
        sample_s    = (slot_cnt_r == CW'(SCAN_DIV - 1));
        frame_end_s = sample_s && (row_idx_r == 2'd3);
        raw_next_s  = raw_r;
        if (sample_s) begin
            raw_next_s[{row_idx_r, 2'b00} +: 4] = ~cols;
        end else begin
            raw_next_s = raw_r;
        end
        m_inc_s  = (m_r == 4'd15) ? 4'd15 : (m_r + 4'd1);
        m_next_s = (raw_next_s == prev_raw_r) ? m_inc_s : 4'd0;
        commit_s = frame_end_s && (m_next_s >= 4'(DEBOUNCE - 1)) && (raw_next_s != held_r);
    end

    // Row slot counter, row stepping (one cycle after each sample) and raw capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_r <= {CW{1'b0}};
            adv_r      <= 1'b0;
            row_idx_r  <= 2'd0;
            rows_r     <= 4'b1110;
            raw_r      <= 16'h0000;
        end else begin
            slot_cnt_r <= sample_s ? {CW{1'b0}} : (slot_cnt_r + CW'(1));
            adv_r      <= sample_s;
            raw_r      <= raw_next_s;
            if (adv_r) begin
                row_idx_r <= row_idx_r + 2'd1;
                rows_r    <= {rows_r[2:0], rows_r[3]};
            end
        end
    end

    // Frame-level debounce history and committed key state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_raw_r <= 16'h0000;
            m_r        <= 4'd0;
            held_r     <= 16'h0000;
            changed_r  <= 16'h0000;
        end else begin
            if (frame_end_s) begin
                m_r        <= m_next_s;
                prev_raw_r <= raw_next_s;
            end
            if (commit_s) begin
                held_r    <= raw_next_s;
                changed_r <= raw_next_s ^ held_r;
            end
        end
    end

    // Emitter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Emitter walks all 16 positions after a commit, pushing one event per changed key.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        push_s       = 1'b0;
        push_data_s  = {key_code(idx_r), held_r[idx_r]};
        case (state_r)
            ST_IDLE: begin
                if (commit_s) begin
                    state_next_s = ST_EMIT;
                    idx_next_s   = 4'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                push_s     = changed_r[idx_r];
                idx_next_s = idx_r + 4'd1;
                if (idx_r == 4'd15) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = 4'd0;
            end
        endcase
    end

    // Queue status; a push into a full queue survives only if the head leaves this cycle.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s   = !empty_s && evt_ready;
        wr_en_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;
        head_s  = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Event queue storage, pointers and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 5'd0;
            end
            wr_ptr_r   <= {(AW + 1){1'b0}};
            rd_ptr_r   <= {(AW + 1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign rows      = rows_r;
    assign held      = held_r;
    assign overflow  = overflow_r;
    assign evt_valid = !empty_s;
    assign evt_code  = head_s[4:1];
    assign evt_press = head_s[0];

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: directed scenarios plus randomized key/ready
// activity, checked every cycle against a frame-level reference model.
module tb_keypad_scan_ctrl;
    localparam int SD = 8;
    localparam int DB = 3;
    localparam int FD = 4;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [3:0]  evt_code;
    logic        evt_press;
    logic [15:0] held;
    logic        overflow;

    logic [15:0] key_mask = 16'h0000;
    int          ready_mode = 0;
    int          checks = 0;
    int          failures = 0;

    // reference model state
    int          cyc;
    logic [15:0] m_raw;
    logic [15:0] m_held;
    logic [15:0] m_changed;
    logic [15:0] hist[$];
    bit          emit_on;
    int          emit_start;
    logic [4:0]  m_q[$];
    bit          m_ovf;
    logic [3:0]  code_tab [16];

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_press(evt_press), .held(held), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        cols = 4'hF;
        case (rows)
            4'b1110: cols = ~key_mask[3:0];
            4'b1101: cols = ~key_mask[7:4];
            4'b1011: cols = ~key_mask[11:8];
            4'b0111: cols = ~key_mask[15:12];
            default: cols = 4'hF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        m_raw = 16'h0;
        m_held = 16'h0;
        m_changed = 16'h0;
        hist.delete();
        hist.push_back(16'h0);
        emit_on = 1'b0;
        emit_start = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int  pre;
        bit  popd;
        int  k;
        int  row;
        bit  same;
        cyc++;
        pre  = m_q.size();
        popd = (pre > 0) && (evt_ready == 1'b1);
        if (popd) void'(m_q.pop_front());
        if (emit_on && cyc >= emit_start && cyc < emit_start + 16) begin
            k = cyc - emit_start;
            if (m_changed[k]) begin
                if (pre == FD && !popd) m_ovf = 1'b1;
                else m_q.push_back({code_tab[k], m_held[k]});
            end
            if (k == 15) emit_on = 1'b0;
        end
        if (cyc % SD == 0) begin
            row = (cyc / SD - 1) % 4;
            m_raw[row*4 +: 4] = key_mask[row*4 +: 4];
            if (row == 3) begin
                hist.push_back(m_raw);
                if (hist.size() > DB) void'(hist.pop_front());
                same = (hist.size() == DB);
                foreach (hist[i]) if (hist[i] != m_raw) same = 1'b0;
                if (same && m_raw != m_held) begin
                    m_changed  = m_raw ^ m_held;
                    m_held     = m_raw;
                    emit_on    = 1'b1;
                    emit_start = cyc + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        int         er;
        logic [3:0] exp_rows;
        er = (cyc == 0) ? 0 : ((cyc - 1) / SD) % 4;
        exp_rows = 4'hF;
        exp_rows[er] = 1'b0;
        chk("rows", rows, exp_rows);
        chk("held", held, m_held);
        chk("evt_valid", evt_valid, (m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("evt_code", evt_code, m_q[0][4:1]);
            chk("evt_press", evt_press, m_q[0][0]);
        end
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        case (ready_mode)
            0:       evt_ready = 1'b1;
            1:       evt_ready = 1'b0;
            default: evt_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        code_tab = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                     4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};
        model_reset();

        // 1: reset state, then release and follow the row sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rows", rows, 4'b1110);
        chk("rst_held", held, 16'h0);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_code", evt_code, 4'd0);
        chk("rst_press", evt_press, 1'b0);
        rst_n = 1'b1;

        // 2: hold '5', commit at third frame end, then release
        key_mask = 16'h0020;
        run_cycles(3 * FRAME);
        chk("t2_held", held, 16'h0020);
        run_cycles(FRAME);
        key_mask = 16'h0000;
        run_cycles(4 * FRAME);
        chk("t2_release", held, 16'h0000);

        // 3: bouncing key never commits
        for (int f = 0; f < 6; f++) begin
            key_mask = (f % 2 == 0) ? 16'h0020 : 16'h0000;
            run_cycles(FRAME);
        end
        chk("t3_held", held, 16'h0000);

        // 4: '1' and 'D' together
        key_mask = 16'h8001;
        run_cycles(4 * FRAME);
        chk("t4_held", held, 16'h8001);
        key_mask = 16'h0000;
        run_cycles(4 * FRAME);

        // 5: consumer stalled, six presses overflow a four-deep queue
        ready_mode = 1;
        evt_ready = 1'b0;
        key_mask = 16'h003F;
        run_cycles(4 * FRAME);
        chk("t5_ovf", overflow, 1'b1);
        chk("t5_head", evt_code, 4'd1);
        ready_mode = 0;
        evt_ready = 1'b1;
        run_cycles(10);
        chk("t5_drained", evt_valid, 1'b0);
        chk("t5_ovf_sticky", overflow, 1'b1);

        // 6: reset in the middle of an emission
        key_mask = 16'h0400;
        guard = 0;
        while (!(emit_on && cyc >= emit_start + 5) && guard < 400) begin
            step();
            guard++;
        end
        chk("t6_reach_emit", (guard < 400), 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", evt_valid, 1'b0);
        chk("t6_held", held, 16'h0);
        chk("t6_rows", rows, 4'b1110);
        chk("t6_ovf", overflow, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(4 * FRAME);
        key_mask = 16'h0000;
        run_cycles(4 * FRAME);

        // 7: randomized keys and consumer back-pressure
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 4) == 0) key_mask = 16'h0000;
            else key_mask = 16'($urandom & $urandom & $urandom);
            ready_mode = $urandom_range(0, 2);
            run_cycles($urandom_range(20, 160));
        end
        ready_mode = 0;
        key_mask = 16'h0000;
        run_cycles(5 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
